// File: rtl/exe_mem_pipe_reg.sv
// EXE -> MEM pipeline register with valid/ready handshake, a one-deep
// skid register behind the main register, and a synchronous flush.
// The main register drives the memory stage; the skid register absorbs
// the single entry that arrives on the cycle the memory stage stalls,
// so in_ready can be a plain register output.
module exe_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  // execute-stage side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [REG_AW-1:0] dest_in,
  // memory-stage side
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [REG_AW-1:0] dest,
  output logic [1:0]        occupancy
);

  // control bits are kept together as {wb_en, mem_read, mem_write}
  logic [2:0]        w_in_ctrl;

  logic              r_main_vld;
  logic [2:0]        r_main_ctrl;
  logic [DATA_W-1:0] r_main_alu;
  logic [DATA_W-1:0] r_main_rm;
  logic [REG_AW-1:0] r_main_dest;

  logic              r_skid_vld;
  logic [2:0]        r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_alu;
  logic [DATA_W-1:0] r_skid_rm;
  logic [REG_AW-1:0] r_skid_dest;

  logic              w_accept;
  logic              w_load_main;
  logic              w_main_from_skid;
  logic              w_main_from_in;
  logic              w_skid_load;

  assign w_in_ctrl = {wb_en_in, mem_read_in, mem_write_in};

  // in_ready is purely registered: the stage can take one more entry as
  // long as the skid slot is free, even if main is stalled.
  assign in_ready  = ~r_skid_vld;
  assign w_accept  = in_valid & in_ready;

  // Main reloads whenever it is empty or its entry leaves this cycle.
  // The skid entry is older than anything on the input, so it wins.
  assign w_load_main      = ~r_main_vld | out_ready;
  assign w_main_from_skid = w_load_main & r_skid_vld;
  assign w_main_from_in   = w_load_main & ~r_skid_vld & w_accept;

  // An accept that cannot go to main (main full and held) parks in skid.
  assign w_skid_load = r_main_vld & ~out_ready & w_accept;

  // ---- main register: valid bit and control bits ----
  // Control bits clear together with the valid bit so an empty stage
  // presents a bubble (no write-back, no memory access) downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_vld  <= 1'b0;
      r_main_ctrl <= 3'b000;
    end else if (flush) begin
      r_main_vld  <= 1'b0;
      r_main_ctrl <= 3'b000;
    end else if (w_load_main) begin
      if (r_skid_vld) begin
        r_main_vld  <= 1'b1;
        r_main_ctrl <= r_skid_ctrl;
      end else if (w_accept) begin
        r_main_vld  <= 1'b1;
        r_main_ctrl <= w_in_ctrl;
      end else begin
        r_main_vld  <= 1'b0;
        r_main_ctrl <= 3'b000;
      end
    end
  end

  // Main register data fields: loaded only with a real entry, otherwise
  // they keep their last value (a bubble does not disturb them).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_alu  <= '0;
      r_main_rm   <= '0;
      r_main_dest <= '0;
    end else if (!flush) begin
      if (w_main_from_skid) begin
        r_main_alu  <= r_skid_alu;
        r_main_rm   <= r_skid_rm;
        r_main_dest <= r_skid_dest;
      end else if (w_main_from_in) begin
        r_main_alu  <= alu_result_in;
        r_main_rm   <= val_rm_in;
        r_main_dest <= dest_in;
      end
    end
  end

  // ---- skid register: valid bit and control bits ----
  // Skid drains into main on any load; it can never fill on the same
  // edge because in_ready is low whenever it is occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= 3'b000;
    end else if (flush) begin
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= 3'b000;
    end else if (w_main_from_skid) begin
      r_skid_vld  <= 1'b0;
    end else if (w_skid_load) begin
      r_skid_vld  <= 1'b1;
      r_skid_ctrl <= w_in_ctrl;
    end
  end

  // Skid register data fields: captured only when an entry parks there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_alu  <= '0;
      r_skid_rm   <= '0;
      r_skid_dest <= '0;
    end else if (!flush && w_skid_load) begin
      r_skid_alu  <= alu_result_in;
      r_skid_rm   <= val_rm_in;
      r_skid_dest <= dest_in;
    end
  end

  // ---- outputs: straight from the main register ----
  assign out_valid  = r_main_vld;
  assign wb_en      = r_main_ctrl[2];
  assign mem_read   = r_main_ctrl[1];
  assign mem_write  = r_main_ctrl[0];
  assign alu_result = r_main_alu;
  assign val_rm_out = r_main_rm;
  assign dest       = r_main_dest;
  assign occupancy  = {1'b0, r_main_vld} + {1'b0, r_skid_vld};

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Bench for exe_mem_pipe_reg: a 32-bit/4-bit instance and a 64-bit/5-bit
// instance driven with the same stimulus, checked against a queue model.
module tb_exe_mem_pipe_reg;

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic        mw;
    logic [63:0] alu;
    logic [63:0] rm;
    logic [4:0]  dest;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, out_ready;
  ent_t din;

  logic        a_in_ready, a_out_valid, a_wb, a_mr, a_mw;
  logic [31:0] a_alu, a_rm;
  logic [3:0]  a_dest;
  logic [1:0]  a_occ;

  logic        b_in_ready, b_out_valid, b_wb, b_mr, b_mw;
  logic [63:0] b_alu, b_rm;
  logic [4:0]  b_dest;
  logic [1:0]  b_occ;

  exe_mem_pipe_reg #(.DATA_W(32), .REG_AW(4)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .wb_en_in(din.wb), .mem_read_in(din.mr), .mem_write_in(din.mw),
    .alu_result_in(din.alu[31:0]), .val_rm_in(din.rm[31:0]), .dest_in(din.dest[3:0]),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .wb_en(a_wb), .mem_read(a_mr), .mem_write(a_mw),
    .alu_result(a_alu), .val_rm_out(a_rm), .dest(a_dest), .occupancy(a_occ)
  );

  exe_mem_pipe_reg #(.DATA_W(64), .REG_AW(5)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .wb_en_in(din.wb), .mem_read_in(din.mr), .mem_write_in(din.mw),
    .alu_result_in(din.alu), .val_rm_in(din.rm), .dest_in(din.dest),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .wb_en(b_wb), .mem_read(b_mr), .mem_write(b_mw),
    .alu_result(b_alu), .val_rm_out(b_rm), .dest(b_dest), .occupancy(b_occ)
  );

  // scoreboard: q[0] is what main should hold, q[1] the skid entry
  ent_t q[$];
  ent_t last;
  int   checks = 0;
  int   errors = 0;

  function automatic ent_t mk(logic wb, logic mr, logic mw,
                              logic [63:0] alu, logic [63:0] rm, logic [4:0] d);
    ent_t e;
    e.wb = wb; e.mr = mr; e.mw = mw; e.alu = alu; e.rm = rm; e.dest = d;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    ent_t       e;
    logic       ev, er;
    logic [1:0] eo;
    if (q.size() > 0) e = q[0];
    else begin
      e = last; e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
    end
    ev = (q.size() > 0);
    er = (q.size() < 2);
    eo = 2'(q.size());
    chk({tag, "/a_ovld"}, 64'(a_out_valid), 64'(ev));
    chk({tag, "/a_irdy"}, 64'(a_in_ready),  64'(er));
    chk({tag, "/a_occ"},  64'(a_occ),       64'(eo));
    chk({tag, "/a_ctrl"}, 64'({a_wb, a_mr, a_mw}), 64'({e.wb, e.mr, e.mw}));
    chk({tag, "/a_alu"},  64'(a_alu),  64'(e.alu[31:0]));
    chk({tag, "/a_rm"},   64'(a_rm),   64'(e.rm[31:0]));
    chk({tag, "/a_dest"}, 64'(a_dest), 64'(e.dest[3:0]));
    chk({tag, "/b_ovld"}, 64'(b_out_valid), 64'(ev));
    chk({tag, "/b_irdy"}, 64'(b_in_ready),  64'(er));
    chk({tag, "/b_occ"},  64'(b_occ),       64'(eo));
    chk({tag, "/b_ctrl"}, 64'({b_wb, b_mr, b_mw}), 64'({e.wb, e.mr, e.mw}));
    chk({tag, "/b_alu"},  b_alu, e.alu);
    chk({tag, "/b_rm"},   b_rm,  e.rm);
    chk({tag, "/b_dest"}, 64'(b_dest), 64'(e.dest));
  endtask

  // drive one cycle from a negedge, update the model at the posedge,
  // check outputs at the following negedge
  task automatic step(string tag, logic iv, logic orr, logic fl, ent_t e);
    bit acc;
    in_valid = iv; out_ready = orr; flush = fl; din = e;
    acc = iv && (q.size() < 2);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (orr && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last = q[0];
    @(negedge clk);
    check_all(tag);
  endtask

  ent_t z;

  initial begin
    z = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    last = '0;
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("reset_rel");

    // stream of four with out_ready high
    for (int i = 0; i < 4; i++)
      step($sformatf("stream%0d", i), 1'b1, 1'b1, 1'b0,
           mk(1'b1, 1'b0, 1'b0, 64'h10 + 64'(i), 64'h100 + 64'(i), 5'(i + 1)));
    step("stream_drain", 1'b0, 1'b1, 1'b0, z);

    // stall: A into main, B into skid, C refused
    step("stall_A", 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 64'hA, 64'hAA, 5'd5));
    step("stall_B", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 64'hB, 64'hBB, 5'd6));
    step("stall_C", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b1, 64'hC, 64'hCC, 5'd7));
    step("release1", 1'b0, 1'b1, 1'b0, z);
    step("release2", 1'b0, 1'b1, 1'b0, z);
    step("release3", 1'b0, 1'b1, 1'b0, z);

    // flush with two held entries and an incoming one
    step("fill1", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 64'h21, 64'h31, 5'd8));
    step("fill2", 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 64'h22, 64'h32, 5'd9));
    step("flush2", 1'b1, 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b1, 64'hC, 64'hCC, 5'd10));
    step("post_flush", 1'b0, 1'b1, 1'b0, z);

    // flush with a simultaneous consume and accept
    step("fill3", 1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 64'h23, 64'h33, 5'd11));
    step("flush_cons", 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 1'b0, 64'h24, 64'h34, 5'd12));

    // store then bubble: data fields hold
    step("store", 1'b1, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b1, 64'h40, 64'hDEADBEEF, 5'd3));
    step("bubble1", 1'b0, 1'b1, 1'b0, z);
    step("bubble2", 1'b0, 1'b1, 1'b0, z);

    // async reset in the middle of a stall
    step("st2_A", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b1, 64'h51, 64'h61, 5'd13));
    step("st2_B", 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 64'h52, 64'h62, 5'd14));
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete(); last = '0;
    check_all("arst");
    @(negedge clk);
    check_all("arst_hold");
    rst = 1'b0;
    step("after_rst", 1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 64'h55, 64'h65, 5'd2));
    step("after_rst2", 1'b0, 1'b1, 1'b0, z);

    // wide values and top destination index
    step("wide", 1'b1, 1'b1, 1'b0,
         mk(1'b1, 1'b1, 1'b0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 5'd31));
    step("wide_stall", 1'b1, 1'b0, 1'b0,
         mk(1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 5'd16));
    step("wide_rel", 1'b0, 1'b1, 1'b0, z);
    step("wide_rel2", 1'b0, 1'b1, 1'b0, z);

    // random traffic with occasional flushes
    for (int i = 0; i < 80; i++)
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
           mk(1'($urandom), 1'($urandom), 1'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
